// File: rtl/avmm_ram_pkg.sv
// Shared types and response codes for the
// Avalon-MM on-chip RAM.
package avmm_ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled single-port RAM, registered read,
// no reset so it maps onto block RAM.
module onchip_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IW         = 10
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [IW-1:0]           i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/avmm_onchip_ram_pipelined.sv
// Avalon-MM slave on-chip RAM with pipelined reads,
// range-checked responses and post-reset zero fill.
module avmm_onchip_ram_pipelined
  import avmm_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic [1:0]              response,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_chk_dp
    $error("DEPTH must be 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_rl
    $error("READ_LATENCY must be 1 or 2");
  end

  state_t                r_state;
  logic [IW-1:0]         r_fill;
  logic                  r_init_done;
  logic                  r_v1;
  logic                  r_err1;
  logic                  r_live1;
  logic                  w_inrange;
  logic                  w_acc;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_fill;
  logic                  w_we;
  logic                  w_re;
  logic [IW-1:0]         w_addr;
  logic [BYTES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_d1;

  assign init_done   = r_init_done;
  assign waitrequest = ~r_init_done | ~clken;

  assign w_inrange = {1'b0, address} < LIMIT;
  assign w_acc     = chipselect & (read | write)
                   & ~waitrequest;
  assign w_acc_wr  = w_acc & write;
  assign w_acc_rd  = w_acc & ~write;

  // fill owns the RAM port while INIT; bus is blocked then
  assign w_fill  = (r_state == ST_INIT) & clken
                 & (INIT_ZERO != 0);
  assign w_we    = w_fill | (w_acc_wr & w_inrange);
  assign w_re    = w_acc_rd & w_inrange;
  assign w_addr  = w_fill ? r_fill : address[IW-1:0];
  assign w_be    = w_fill ? '1 : byteenable;
  assign w_wdata = w_fill ? '0 : writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_fill      <= '0;
      r_init_done <= 1'b0;
    end else if (clken) begin
      unique case (r_state)
        ST_INIT: begin
          if (INIT_ZERO == 0 || r_fill == LAST) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
            r_fill      <= '0;
          end else begin
            r_fill <= r_fill + 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_core (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // live tracks whether the core register holds real data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_err1  <= 1'b0;
      r_live1 <= 1'b0;
    end else if (clken) begin
      r_v1 <= w_acc_rd;
      if (w_acc_rd) begin
        r_err1  <= ~w_inrange;
        r_live1 <= w_inrange;
      end
    end
  end

  assign w_d1 = r_live1 ? w_rdata : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_v2;
    logic                  r_err2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_v2   <= 1'b0;
        r_err2 <= 1'b0;
        r_d2   <= '0;
      end else if (clken) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_err2 <= r_err1;
          r_d2   <= w_d1;
        end
      end
    end

    assign readdatavalid = r_v2 & clken;
    assign readdata      = r_d2;
    assign response      = r_err2 ? RESP_SLVERR
                                  : RESP_OKAY;
  end else begin : g_lat1
    assign readdatavalid = r_v1 & clken;
    assign readdata      = w_d1;
    assign response      = r_err1 ? RESP_SLVERR
                                  : RESP_OKAY;
  end

endmodule

// File: tb/tb_avmm_onchip_ram_pipelined.sv
// Randomised + directed bench for the pipelined
// Avalon-MM RAM, latency 1 and 2 side by side.
module tb_avmm_onchip_ram_pipelined;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 16;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic          cs;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          clken;

  logic [DW-1:0] rdata1, rdata2;
  logic          rdv1, rdv2;
  logic [1:0]    resp1, resp2;
  logic          wreq1, wreq2;
  logic          idone1, idone2;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mem [DP];
  logic [31:0] last1, last2;
  int          init_left;
  int          en_cnt;
  int          n_pass;
  int          n_chk;

  avmm_onchip_ram_pipelined #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DP),
    .READ_LATENCY (1), .INIT_ZERO (1)
  ) u_l1 (
    .clk (clk), .reset_n (reset_n), .address (addr),
    .byteenable (be), .chipselect (cs), .read (rd),
    .write (wr), .writedata (wdata), .clken (clken),
    .readdata (rdata1), .readdatavalid (rdv1),
    .response (resp1), .waitrequest (wreq1),
    .init_done (idone1)
  );

  avmm_onchip_ram_pipelined #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DP),
    .READ_LATENCY (2), .INIT_ZERO (1)
  ) u_l2 (
    .clk (clk), .reset_n (reset_n), .address (addr),
    .byteenable (be), .chipselect (cs), .read (rd),
    .write (wr), .writedata (wdata), .clken (clken),
    .readdata (rdata2), .readdatavalid (rdv2),
    .response (resp2), .waitrequest (wreq2),
    .init_done (idone2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  task automatic check_dut(input int lat,
                           input logic v,
                           input logic [31:0] d,
                           input logic [1:0] r);
    exp_t e;
    bit   due;
    bit   empty;
    due = 1'b0;
    if (lat == 1) begin
      empty = (q1.size() == 0);
      if (!empty) due = clken && q1[0].due == en_cnt;
    end else begin
      empty = (q2.size() == 0);
      if (!empty) due = clken && q2[0].due == en_cnt;
    end
    chk($sformatf("valid_l%0d", lat), v, due);
    if (due) begin
      if (lat == 1) begin
        e = q1.pop_front();
        last1 = e.d;
      end else begin
        e = q2.pop_front();
        last2 = e.d;
      end
      chk($sformatf("rdata_l%0d", lat), d, e.d);
      chk($sformatf("resp_l%0d", lat), r, e.r);
    end else if (empty) begin
      chk($sformatf("hold_l%0d", lat), d,
          lat == 1 ? last1 : last2);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("init_done_l1", idone1, init_left == 0);
    chk("init_done_l2", idone2, init_left == 0);
    chk("waitreq_l1", wreq1, init_left != 0 || !clken);
    chk("waitreq_l2", wreq2, init_left != 0 || !clken);
    check_dut(1, rdv1, rdata1, resp1);
    check_dut(2, rdv2, rdata2, resp2);
    if (init_left == 0 && clken && cs && (rd || wr)) begin
      if (wr) begin
        if (addr < DP) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr[3:0]][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end else begin
        e.d = (addr < DP) ? mem[addr[3:0]] : 32'h0;
        e.r = (addr < DP) ? 2'b00 : 2'b10;
        e.due = en_cnt + 1;
        q1.push_back(e);
        e.due = en_cnt + 2;
        q2.push_back(e);
      end
    end
    if (clken) begin
      if (init_left > 0) begin
        mem[DP - init_left] = 32'h0;
        init_left--;
      end
      en_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid_l1", rdv1, 1'b0);
    chk("rst_valid_l2", rdv2, 1'b0);
    chk("rst_rdata_l1", rdata1, 32'h0);
    chk("rst_rdata_l2", rdata2, 32'h0);
    chk("rst_resp_l1", resp1, 2'b00);
    chk("rst_resp_l2", resp2, 2'b00);
    chk("rst_waitreq", wreq1, 1'b1);
    chk("rst_init_done", idone2, 1'b0);
    q1.delete();
    q2.delete();
    init_left = DP;
    last1 = '0;
    last2 = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (n) step();
  endtask

  task automatic bus(input bit w, input int a,
                     input logic [3:0] b,
                     input logic [31:0] d);
    cs = 1'b1; rd = !w; wr = w;
    addr = AW'(a); be = b; wdata = d;
    step();
  endtask

  initial begin
    reset_n = 1'b1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; be = '0; wdata = '0; clken = 1'b1;
    n_pass = 0; n_chk = 0; en_cnt = 0;
    for (int i = 0; i < DP; i++) mem[i] = 32'hxxxxxxxx;
    #2;
    do_reset();

    idle(DP + 1);
    for (int a = 0; a < DP; a++) bus(0, a, 4'hf, 0);
    idle(3);

    bus(1, 5, 4'b1111, 32'hDEADBEEF);
    bus(1, 5, 4'b0001, 32'h000000AA);
    bus(0, 5, 4'hf, 0);
    idle(3);

    for (int a = 0; a < 4; a++) bus(1, a, 4'hf, 32'h10 + a);
    for (int a = 0; a < 4; a++) bus(0, a, 4'hf, 0);
    idle(3);

    bus(0, DP, 4'hf, 0);
    bus(1, DP, 4'hf, 32'h55);
    bus(0, 0, 4'hf, 0);
    idle(3);

    bus(0, 5, 4'hf, 0);
    clken = 1'b0;
    repeat (3) step();
    clken = 1'b1;
    idle(4);

    bus(0, 5, 4'hf, 0);
    do_reset();
    idle(5);
    do_reset();
    idle(3);
    clken = 1'b0;
    idle(2);
    clken = 1'b1;
    idle(DP);
    bus(0, 5, 4'hf, 0);
    bus(0, 15, 4'hf, 0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      cs    = ($urandom % 4) != 0;
      rd    = $urandom % 2;
      wr    = ($urandom % 3) == 0;
      addr  = AW'($urandom_range(0, DP + 1));
      be    = 4'($urandom);
      wdata = $urandom;
      clken = ($urandom % 5) != 0;
      step();
    end
    clken = 1'b1;
    idle(4);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
